// File: rtl/yari_mem_arbiter_if.sv
// Bus bundles for the yari memory arbiter: one requester port and the shared memory port.
interface yari_port_if;
  logic [29:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  writedatamask;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (output address, read, write, writedata, writedatamask,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, writedatamask,
                  output waitrequest, readdata, readdatavalid);
endinterface

interface yari_mem_if;
  logic [1:0]  id;
  logic [29:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  writedatamask;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  readdataid;

  modport master (output id, address, read, write, writedata, writedatamask,
                  input  waitrequest, readdata, readdataid);
  modport slave  (input  id, address, read, write, writedata, writedatamask,
                  output waitrequest, readdata, readdataid);
endinterface

// File: rtl/yari_mem_arbiter.sv
// Three-port memory arbiter: fixed priority with aging override, grant lock across
// waitrequest, ID-tagged read return routing and an outstanding-read cap.
module yari_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic       clock,
  input  logic       rst,
  yari_port_if.slave p0,
  yari_port_if.slave p1,
  yari_port_if.slave p2,
  yari_mem_if.master mem
);
  localparam logic [7:0] AGE_MAX = 8'(STARVE_LIMIT);
  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  logic [2:0]  rd, wr, req, elig, aged, gnt, acc;
  logic [29:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wmask [3];
  logic [7:0]  age   [3];
  logic [3:0]  outstanding;
  logic        lock;
  logic [1:0]  lock_idx;
  logic [1:0]  sel;
  logic        gv;
  logic        accept, inc, dec;

  assign rd  = {p2.read,  p1.read,  p0.read};
  assign wr  = {p2.write, p1.write, p0.write};
  assign req = rd | wr;

  assign addr[0]  = p0.address;       assign addr[1]  = p1.address;       assign addr[2]  = p2.address;
  assign wdata[0] = p0.writedata;     assign wdata[1] = p1.writedata;     assign wdata[2] = p2.writedata;
  assign wmask[0] = p0.writedatamask; assign wmask[1] = p1.writedatamask; assign wmask[2] = p2.writedatamask;

  // Eligibility uses the registered count, so a same-cycle return frees the slot only next cycle.
  always_comb begin
    elig = '0;
    aged = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i] = wr[i] | (rd[i] & (outstanding != OUT_MAX));
      aged[i] = elig[i] & (age[i] == AGE_MAX);
    end
  end

  always_comb begin
    sel = 2'd0;
    gv  = 1'b0;
    if (!rst) begin
      gv = 1'b0;
    end else if (lock) begin
      sel = lock_idx;
      gv  = 1'b1;
    end else if (aged != 3'b000) begin
      gv  = 1'b1;
      sel = aged[0] ? 2'd0 : (aged[1] ? 2'd1 : 2'd2);
    end else if (elig != 3'b000) begin
      gv  = 1'b1;
      sel = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
    end
  end

  assign gnt    = gv ? (3'b001 << sel) : 3'b000;
  assign accept = gv & (rd[sel] | wr[sel]) & ~mem.waitrequest;
  assign acc    = accept ? gnt : 3'b000;
  assign inc    = accept & rd[sel];
  assign dec    = (mem.readdataid != 2'd0) & (outstanding != 4'd0);

  assign mem.id            = gv ? (sel + 2'd1) : 2'd0;
  assign mem.address       = gv ? addr[sel]  : '0;
  assign mem.read          = gv & rd[sel];
  assign mem.write         = gv & wr[sel];
  assign mem.writedata     = gv ? wdata[sel] : '0;
  assign mem.writedatamask = gv ? wmask[sel] : '0;

  assign p0.waitrequest = ~gnt[0] | mem.waitrequest;
  assign p1.waitrequest = ~gnt[1] | mem.waitrequest;
  assign p2.waitrequest = ~gnt[2] | mem.waitrequest;

  assign p0.readdata = mem.readdata;
  assign p1.readdata = mem.readdata;
  assign p2.readdata = mem.readdata;
  assign p0.readdatavalid = (mem.readdataid == 2'd1);
  assign p1.readdatavalid = (mem.readdataid == 2'd2);
  assign p2.readdatavalid = (mem.readdataid == 2'd3);

  always_ff @(posedge clock) begin
    if (!rst) begin
      lock        <= 1'b0;
      lock_idx    <= 2'd0;
      outstanding <= 4'd0;
      for (int i = 0; i < 3; i++) age[i] <= 8'd0;
    end else begin
      lock <= gv & mem.waitrequest;
      if (gv & mem.waitrequest) lock_idx <= sel;

      if (inc & ~dec)      outstanding <= outstanding + 4'd1;
      else if (dec & ~inc) outstanding <= outstanding - 4'd1;

      for (int i = 0; i < 3; i++) begin
        if (!req[i] || acc[i])
          age[i] <= 8'd0;
        else if (elig[i] && !gnt[i] && age[i] != AGE_MAX)
          age[i] <= age[i] + 8'd1;
      end
    end
  end
endmodule

// File: doc/yari_mem_arbiter.md
# yari_mem_arbiter

Three-requester arbiter for the single external memory port of the yari core. It replaces the inline static-priority dmem/imem mux with a registered arbiter that adds a third requester (aux, e.g. a DMA or framebuffer fetcher), prevents starvation through per-port aging, and holds each grant stable across `mem_waitrequest`. It also tags each transaction with a port ID, routes read data back by `mem_readdataid`, and caps the number of outstanding reads.

## Interface
- `STARVE_LIMIT`, 8: consecutive lost cycles after which a pending port overrides priority (1..255).
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unreturned reads (1..15).
- `clock`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `pN_address`  in  30  word address, for N = 0 (dcache, ID 1), 1 (icache, ID 2), 2 (aux, ID 3).
- `pN_read`, `pN_write`  in  1  request strobes; at most one per port at a time.
- `pN_writedata`  in  32  write data.
- `pN_writedatamask`  in  4  byte enables.
- `pN_waitrequest`  out  1  request not accepted this cycle.
- `pN_readdata`  out  32  returned data, equal to `mem_readdata`.
- `pN_readdatavalid`  out  1  high when `mem_readdataid` equals the port's ID.
- `mem_id`  out  2  ID of the granted port; 0 when idle.
- `mem_address`  out  30  address of the granted port.
- `mem_read`, `mem_write`  out  1  strobes of the granted port.
- `mem_writedata`  out  32  write data of the granted port.
- `mem_writedatamask`  out  4  byte enables of the granted port.
- `mem_waitrequest`  in  1  memory stall.
- `mem_readdata`  in  32  memory read data.
- `mem_readdataid`  in  2  ID of the returning read; 0 means no data.

## Operation
- **Eligibility.** Port N is eligible when `pN_read` or `pN_write` is high. If `outstanding == MAX_OUTSTANDING`, a read is not eligible; writes remain eligible.
- **Unlocked arbitration** (`lock == 0`) is combinational in the same cycle.
  - Any aged eligible port wins, lowest index first. A port is aged when `age[N] == STARVE_LIMIT`.
  - Otherwise the fixed priority is p0 > p1 > p2.
- **Grant lock.** If a grant issues and `mem_waitrequest == 1`, register `lock = 1` and `lock_idx = winner`. While locked, the mux selects `lock_idx` unconditionally.
  - The lock clears on the first cycle with `mem_waitrequest == 0`, which is acceptance.
  - Requesters must hold their request stable while stalled. A locked read that is blocked by the cap is not possible, because it was already counted as eligible when granted.
- **waitrequest.** `pN_waitrequest = ~(granted_N) | mem_waitrequest`.
- **Aging.** `age[N]` (8-bit) increments, saturating at `STARVE_LIMIT`, on each cycle port N is eligible but not granted. It resets to 0 when port N's request is accepted or when port N is not requesting.
- **Outstanding counter** (4-bit):
  - +1 on an accepted read;
  - −1 when `mem_readdataid != 0`;
  - unchanged when both happen in the same cycle.
  - Underflow with no reads outstanding is ignored (held at 0).
- **Read return.** Routing depends only on `mem_readdataid`, never on the current grant. Returns may arrive while a different port is granted.
- **Write-data muxing.** `mem_writedata` and `mem_writedatamask` follow the grant. When idle they drive 0.

## Timing
- Grant latency is 0 cycles: request in cycle t produces `mem_*` in cycle t when unlocked.
- Acceptance occurs in the cycle where the port's strobe is high, the grant is on port N, and `mem_waitrequest == 0`.
- Lock state set in cycle t takes effect in cycle t+1 and persists until acceptance.
- While `rst == 0`:
  - `mem_read = mem_write = 0`, `mem_id = 0`;
  - all `pN_waitrequest = 1`;
  - on the clock edge, `lock`, all `age`, and `outstanding` reset to 0.
- `pN_readdatavalid` and `pN_readdata` stay combinational pass-throughs even in reset.
- Reset asserted mid-lock: the lock is dropped and the transaction is abandoned. Reads already outstanding in memory may still return and are routed normally; the counter stays at 0.
- A simultaneous return on the cap boundary frees the slot in the same cycle for the next cycle's eligibility, not the current one. Eligibility uses the registered count.

## Test plan
- **Priority:** p0 and p1 read together with `mem_waitrequest = 0` → p0 granted at t, `mem_id = 1`; p1 granted at t+1, `mem_id = 2`.
- **Lock:** p1 read at address `0x100` is granted. `mem_waitrequest` is held high for 3 cycles while p0 raises a read. Required: the grant stays on p1 with `mem_address = 0x100` for all stalled cycles. p1 is accepted on the 4th cycle, then p0 is granted.
- **Starvation:** `STARVE_LIMIT = 8`, p0 requests continuously and p2 requests continuously. Required: p2 is granted on the 9th cycle (`mem_id = 3`), and its age returns to 0 afterwards.
- **Outstanding cap:** `MAX_OUTSTANDING = 4`, 4 reads are accepted and no data returns. Required:
  - a 5th read from p1 sees `p1_waitrequest = 1` while a p0 write is accepted;
  - after one return with `mem_readdataid = 2`, the p1 read is granted the next cycle.
- **Return routing:** p2 is granted and writing when `mem_readdataid = 1` with data `0xDEADBEEF`. Required: `p0_readdatavalid = 1`, `p0_readdata = 0xDEADBEEF`, and `p1_readdatavalid = p2_readdatavalid = 0`.
- **Reset:** `rst` is driven low during a locked stall with 2 reads outstanding. Required:
  - strobes go to 0 immediately;
  - `lock` and `outstanding` are 0 after the edge;
  - after `rst` rises, a p1 read is granted at once.
